// File: rtl/muldiv_ctrl_pkg.sv
// Shared definitions for the iterative multiply/divide unit: FSM encoding,
// iteration count and the two operand constants that trigger a divide overflow.
package muldiv_ctrl_pkg;

    localparam int ITER = 32;

    localparam logic [31:0] INT_MIN = 32'h8000_0000;
    localparam logic [31:0] NEG_ONE = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        MUL   = 3'd1,
        NEG_A = 3'd2,
        NEG_B = 3'd3,
        DIV   = 3'd4,
        NEG_Q = 3'd5,
        DONE  = 3'd6
    } state_t;

endpackage

// File: rtl/muldiv_ctrl_if.sv
// Start/operand/result bundle between the ALU issue logic (master) and the
// multiply/divide unit (slave).
interface muldiv_ctrl_if;
    // Handshake: ctrl_MULT / ctrl_DIV are single-cycle start pulses that also
    // capture the operands; data_resultRDY is a one-cycle completion strobe and
    // data_result / data_exception are valid in that cycle and hold afterwards.
    logic        ctrl_MULT;
    logic        ctrl_DIV;
    logic [31:0] data_operandA;
    logic [31:0] data_operandB;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;

    modport master (
        output ctrl_MULT, ctrl_DIV, data_operandA, data_operandB,
        input  data_result, data_exception, data_resultRDY
    );

    modport slave (
        input  ctrl_MULT, ctrl_DIV, data_operandA, data_operandB,
        output data_result, data_exception, data_resultRDY
    );
endinterface

// File: rtl/Adder32.sv
// 32-bit carry-select adder: the low half ripples, the high half is computed
// for both carry-ins and selected by the low-half carry.
module Adder32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cin,
    output logic [31:0] sum,
    output logic        cout
);
    logic [16:0] lo_sum;
    logic [16:0] hi_sum0;
    logic [16:0] hi_sum1;

    assign lo_sum  = {1'b0, a[15:0]} + {1'b0, b[15:0]} + {16'd0, cin};
    assign hi_sum0 = {1'b0, a[31:16]} + {1'b0, b[31:16]};
    assign hi_sum1 = {1'b0, a[31:16]} + {1'b0, b[31:16]} + 17'd1;

    assign sum  = {(lo_sum[16] ? hi_sum1[15:0] : hi_sum0[15:0]), lo_sum[15:0]};
    assign cout = lo_sum[16] ? hi_sum1[16] : hi_sum0[16];
endmodule

// File: rtl/muldiv_ctrl.sv
// Iterative signed 32-bit multiply (radix-2 Booth) and divide (restoring on
// magnitudes) sharing one Adder32 across all add, subtract and negate passes.
module muldiv_ctrl
    import muldiv_ctrl_pkg::*;
(
    input  logic         clock,
    input  logic         reset_n,
    muldiv_ctrl_if.slave bus,
    output state_t       dbg_state
);

    state_t      state_q, state_d;
    logic [5:0]  cnt_q;
    logic [31:0] acc_q;      // hi during MUL, rem during DIV
    logic [31:0] lo_q;       // lo (multiplier) during MUL, dividend/quo during DIV
    logic [31:0] m_q;        // M during MUL, divisor magnitude during DIV
    logic        q1_q;
    logic        is_div_q;
    logic        sign_q;
    logic        div0_q;
    logic        ovf_q;

    logic [31:0] result_q;
    logic        exception_q;
    logic        rdy_q;

    logic        start_mul;
    logic        start_div;
    logic        last_iter;

    logic [31:0] add_a;
    logic [31:0] add_b;
    logic        add_cin;
    logic [31:0] add_sum;
    logic        add_cout;
    logic        wr_lo_neg;
    logic        wr_m_neg;
    logic        mul_sign;
    logic        mul_exc;
    logic        exc;

    // MULT has priority when both start pulses arrive together.
    assign start_mul = bus.ctrl_MULT;
    assign start_div = bus.ctrl_DIV & ~bus.ctrl_MULT;
    assign last_iter = (cnt_q == 6'(ITER - 1));

    Adder32 u_adder (
        .a    (add_a),
        .b    (add_b),
        .cin  (add_cin),
        .sum  (add_sum),
        .cout (add_cout)
    );

    // True sign of the 33-bit Booth partial sum, so that hi - INT_MIN does not
    // corrupt the arithmetic shift.
    assign mul_sign = add_a[31] ^ add_b[31] ^ add_cout;

    assign mul_exc = ~((&{acc_q, lo_q[31]}) | ~(|{acc_q, lo_q[31]}));
    assign exc     = is_div_q ? (div0_q | ovf_q) : mul_exc;

    // State register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (start_mul) begin
            state_d = MUL;
        end else if (start_div) begin
            state_d = NEG_A;
        end else begin
            case (state_q)
                IDLE:    state_d = IDLE;
                MUL:     state_d = last_iter ? DONE : MUL;
                NEG_A:   state_d = NEG_B;
                NEG_B:   state_d = DIV;
                DIV:     state_d = last_iter ? NEG_Q : DIV;
                NEG_Q:   state_d = DONE;
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Output logic: adder operand muxes and negate write-back enables
    always_comb begin
        add_a     = '0;
        add_b     = '0;
        add_cin   = 1'b0;
        wr_lo_neg = 1'b0;
        wr_m_neg  = 1'b0;
        case (state_q)
            MUL: begin
                add_a = acc_q;
                case ({lo_q[0], q1_q})
                    2'b01:   add_b = m_q;
                    2'b10: begin
                        add_b   = ~m_q;
                        add_cin = 1'b1;
                    end
                    default: add_b = '0;
                endcase
            end
            NEG_A: begin
                add_b     = ~lo_q;
                add_cin   = 1'b1;
                wr_lo_neg = lo_q[31];
            end
            NEG_B: begin
                add_b    = ~m_q;
                add_cin  = 1'b1;
                wr_m_neg = m_q[31];
            end
            DIV: begin
                add_a   = {acc_q[30:0], lo_q[31]};
                add_b   = ~m_q;
                add_cin = 1'b1;
            end
            NEG_Q: begin
                add_b     = ~lo_q;
                add_cin   = 1'b1;
                wr_lo_neg = sign_q;
            end
            default: ;
        endcase
    end

    // Datapath and registered outputs
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q       <= '0;
            acc_q       <= '0;
            lo_q        <= '0;
            m_q         <= '0;
            q1_q        <= 1'b0;
            is_div_q    <= 1'b0;
            sign_q      <= 1'b0;
            div0_q      <= 1'b0;
            ovf_q       <= 1'b0;
            result_q    <= '0;
            exception_q <= 1'b0;
            rdy_q       <= 1'b0;
        end else begin
            rdy_q <= 1'b0;
            // DONE still reports even when a new start lands in the same cycle.
            if (state_q == DONE) begin
                result_q    <= exc ? 32'd0 : lo_q;
                exception_q <= exc;
                rdy_q       <= 1'b1;
            end

            if (start_mul || start_div) begin
                cnt_q    <= '0;
                acc_q    <= '0;
                q1_q     <= 1'b0;
                is_div_q <= start_div;
                sign_q   <= 1'b0;
                div0_q   <= 1'b0;
                ovf_q    <= 1'b0;
                lo_q     <= start_mul ? bus.data_operandB : bus.data_operandA;
                m_q      <= start_mul ? bus.data_operandA : bus.data_operandB;
            end else begin
                case (state_q)
                    MUL: begin
                        acc_q <= {mul_sign, add_sum[31:1]};
                        lo_q  <= {add_sum[0], lo_q[31:1]};
                        q1_q  <= lo_q[0];
                        cnt_q <= last_iter ? 6'd0 : cnt_q + 6'd1;
                    end
                    NEG_A: begin
                        if (wr_lo_neg) lo_q <= add_sum;
                        sign_q <= lo_q[31] ^ m_q[31];
                        ovf_q  <= (lo_q == INT_MIN) && (m_q == NEG_ONE);
                    end
                    NEG_B: begin
                        if (wr_m_neg) m_q <= add_sum;
                        div0_q <= (m_q == 32'd0);
                    end
                    DIV: begin
                        acc_q <= add_cout ? add_sum : add_a;
                        lo_q  <= {lo_q[30:0], add_cout};
                        cnt_q <= last_iter ? 6'd0 : cnt_q + 6'd1;
                    end
                    NEG_Q: begin
                        if (wr_lo_neg) lo_q <= add_sum;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.data_result    = result_q;
    assign bus.data_exception = exception_q;
    assign bus.data_resultRDY = rdy_q;
    assign dbg_state          = state_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed bench for muldiv_ctrl: fixed-latency MULT/DIV results, exceptions,
// abort-by-restart, mid-operation reset and start-priority.
module tb_muldiv_ctrl;
    import muldiv_ctrl_pkg::*;

    logic   clock = 1'b0;
    logic   reset_n = 1'b0;
    state_t dbg_state;
    int     checks = 0;
    int     errors = 0;

    muldiv_ctrl_if bus ();

    muldiv_ctrl dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drives one start pulse; returns at the falling edge right after the
    // sampling rising edge.
    task automatic drive_start(input logic mul, input logic div,
                               input logic [31:0] a, input logic [31:0] b);
        @(negedge clock);
        bus.ctrl_MULT     = mul;
        bus.ctrl_DIV      = div;
        bus.data_operandA = a;
        bus.data_operandB = b;
        @(negedge clock);
        bus.ctrl_MULT = 1'b0;
        bus.ctrl_DIV  = 1'b0;
    endtask

    // Latency counted in rising edges after the start edge; -1 on timeout.
    task automatic wait_rdy(input int budget, output int lat);
        lat = -1;
        for (int k = 1; k <= budget; k++) begin
            @(negedge clock);
            if (bus.data_resultRDY === 1'b1) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic run_op(input string tag, input logic mul, input logic div,
                          input logic [31:0] a, input logic [31:0] b,
                          input int exp_lat, input logic [31:0] exp_res,
                          input logic exp_exc);
        int lat;
        drive_start(mul, div, a, b);
        wait_rdy(60, lat);
        chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_res"}, bus.data_result, exp_res);
        chk({tag, "_exc"}, {31'd0, bus.data_exception}, {31'd0, exp_exc});
        @(negedge clock);
        chk({tag, "_rdy_drop"}, {31'd0, bus.data_resultRDY}, 32'd0);
        chk({tag, "_hold"}, bus.data_result, exp_res);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lat;
        int early;

        bus.ctrl_MULT     = 1'b0;
        bus.ctrl_DIV      = 1'b0;
        bus.data_operandA = '0;
        bus.data_operandB = '0;

        repeat (3) @(negedge clock);
        chk("reset_res", bus.data_result, 32'd0);
        chk("reset_exc", {31'd0, bus.data_exception}, 32'd0);
        chk("reset_rdy", {31'd0, bus.data_resultRDY}, 32'd0);
        chk("reset_state", 32'(dbg_state), 32'(IDLE));
        reset_n = 1'b1;
        repeat (2) @(negedge clock);
        chk("idle_state", 32'(dbg_state), 32'(IDLE));

        run_op("mul_7x-3",      1'b1, 1'b0, 32'd7,          32'hFFFF_FFFD, 33, 32'hFFFF_FFEB, 1'b0);
        run_op("mul_ovf",       1'b1, 1'b0, 32'h0001_0000,  32'h0001_0000, 33, 32'd0,         1'b1);
        run_op("mul_intmin_x1", 1'b1, 1'b0, 32'h8000_0000,  32'd1,         33, 32'h8000_0000, 1'b0);
        run_op("mul_-5x6",      1'b1, 1'b0, 32'hFFFF_FFFB,  32'd6,         33, 32'hFFFF_FFE2, 1'b0);
        run_op("div_-100/7",    1'b0, 1'b1, 32'hFFFF_FF9C,  32'd7,         36, 32'hFFFF_FFF2, 1'b0);
        run_op("div_100/-7",    1'b0, 1'b1, 32'd100,        32'hFFFF_FFF9, 36, 32'hFFFF_FFF2, 1'b0);
        run_op("div_0/5",       1'b0, 1'b1, 32'd0,          32'd5,         36, 32'd0,         1'b0);
        run_op("div_-7/-2",     1'b0, 1'b1, 32'hFFFF_FFF9,  32'hFFFF_FFFE, 36, 32'd3,         1'b0);
        run_op("div_5/0",       1'b0, 1'b1, 32'd5,          32'd0,         36, 32'd0,         1'b1);
        run_op("div_min/-1",    1'b0, 1'b1, 32'h8000_0000,  32'hFFFF_FFFF, 36, 32'd0,         1'b1);

        // Abort: MULT 3*4 at edge N, DIV 20/6 sampled at edge N+10.
        early = 0;
        drive_start(1'b1, 1'b0, 32'd3, 32'd4);
        repeat (8) begin
            @(negedge clock);
            if (bus.data_resultRDY === 1'b1) early++;
        end
        drive_start(1'b0, 1'b1, 32'd20, 32'd6);
        wait_rdy(60, lat);
        chk("abort_no_early_rdy", 32'(early), 32'd0);
        chk("abort_lat", 32'(lat), 32'd36);
        chk("abort_res", bus.data_result, 32'd3);
        chk("abort_exc", {31'd0, bus.data_exception}, 32'd0);
        @(negedge clock);
        chk("abort_rdy_drop", {31'd0, bus.data_resultRDY}, 32'd0);

        // Reset asserted ahead of edge N+15 of a running MULT.
        drive_start(1'b1, 1'b0, 32'd5, 32'd6);
        repeat (14) @(negedge clock);
        reset_n = 1'b0;
        #1;
        chk("midrst_res", bus.data_result, 32'd0);
        chk("midrst_exc", {31'd0, bus.data_exception}, 32'd0);
        chk("midrst_rdy", {31'd0, bus.data_resultRDY}, 32'd0);
        chk("midrst_state", 32'(dbg_state), 32'(IDLE));
        @(negedge clock);
        reset_n = 1'b1;
        early = 0;
        repeat (40) begin
            @(negedge clock);
            if (bus.data_resultRDY === 1'b1) early++;
        end
        chk("midrst_no_rdy", 32'(early), 32'd0);
        chk("midrst_res_hold", bus.data_result, 32'd0);

        // Both starts high: MULT wins.
        run_op("both_mul_-1x-1", 1'b1, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, 32'd1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/muldiv_ctrl.md
# muldiv_ctrl

Iterative signed 32-bit multiply/divide unit that sequences a single shared `Adder32` carry-select adder over many cycles. It sits in the ALU beside the single-cycle paths and serves MULT/DIV instructions. The processor stalls until `data_resultRDY`. Multiply uses radix-2 Booth; divide uses restoring division on magnitudes, with sign fix-up passes through the same adder.

## Interface
- `ITER`, 32: iteration count, which equals the operand width.
- `clock` in 1: sole clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `ctrl_MULT` in 1: start-multiply pulse, sampled at a rising edge.
- `ctrl_DIV` in 1: start-divide pulse, sampled at a rising edge.
- `data_operandA` in 32: multiplicand or dividend (signed); captured on start.
- `data_operandB` in 32: multiplier or divisor (signed); captured on start.
- `data_result` out 32: product low word, or quotient truncated toward zero.
- `data_exception` out 1: multiply overflow, divide by zero, or −2³¹/−1.
- `data_resultRDY` out 1: one-cycle completion strobe.

## Operation
- **States:** IDLE, MUL, NEG_A, NEG_B, DIV, NEG_Q, DONE.
- **Reset:**
  - State goes to IDLE and the counter to 0.
  - `data_result` = 0, `data_exception` = 0, `data_resultRDY` = 0.
- **Start in IDLE:**
  - `ctrl_MULT` goes to MUL.
  - `ctrl_DIV` goes to NEG_A.
  - If both are high, MULT wins and DIV is ignored.
- **MUL (ITER cycles):**
  - Registers are hi[31:0], lo[31:0] (= B), q₋₁ = 0, and M = A.
  - Per cycle, {lo[0], q₋₁} = 01 gives hi + M; 10 gives hi + ~M with c_in = 1; otherwise hi is unchanged.
  - Then arithmetic shift right of {hi, lo, q₋₁}.
  - After ITER cycles, go to DONE.
  - Result is lo.
  - Exception if {hi, lo[31]} is not all-zeros or all-ones.
- **NEG_A / NEG_B:**
  - One adder pass each: x ← ~x + 1 when x is negative, otherwise pass x through with no adder write-back.
  - Record the sign of A XOR B.
  - Flag divide-by-zero when B == 0.
  - Flag overflow when A = 0x80000000 and B = 0xFFFFFFFF.
- **DIV (ITER cycles):**
  - Registers are rem[31:0] and quo = |A|.
  - Per cycle, shift {rem, quo} left 1 and compute trial = rem + ~|B| + 1.
  - If c_out = 1, then rem ← trial and quo[0] ← 1.
- **NEG_Q:** negate quo through the adder if the result sign is negative.
- **Exception outcome:** on any exception, `data_result` = 0 and `data_exception` = 1.
- **DONE:**
  - Register the result and exception.
  - `data_resultRDY` = 1 for one cycle, then return to IDLE.
- **Output hold:** `data_result` and `data_exception` hold until the next start or reset.
- **Adder sharing:**
  - Exactly one `Adder32` instance.
  - Operand a muxes from hi, rem, or the negate target.
  - Operand b muxes from M, ~M, ~|B|, or ~x.
  - c_in is 1 for every subtract or negate.
- **Start while busy:** a new `ctrl_MULT` or `ctrl_DIV` in any non-IDLE state aborts the current operation and restarts with the new operands. No `data_resultRDY` is emitted for the aborted operation.
- **Start in DONE:** `data_resultRDY` still pulses that cycle, and the new operation proceeds.

## Timing
- Latency is fixed regardless of operand values, signs or exceptions.
- Start sampled at edge N:
  - MULT: `data_resultRDY` is high in the cycle after edge N+33.
  - DIV: `data_resultRDY` is high in the cycle after edge N+36 (the count includes NEG_A, NEG_B and NEG_Q).
- `data_result` is valid in the same cycle as `data_resultRDY`.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Reset asserted mid-operation:
  - Immediate return to IDLE.
  - No `data_resultRDY` pulse.
  - Outputs cleared.
- Start pulses longer than one cycle are treated as restarts every cycle. The caller must pulse for exactly one cycle.

## Structure
- `common/muldiv_defs.vh` (include-guarded) holds:
  - state encodings (3-bit localparams),
  - `ITER`,
  - the constants `INT_MIN` = 0x80000000 and `NEG_ONE` = 0xFFFFFFFF.
- The only sub-module is `Adder32`, instantiated once. No separate negator or incrementer is allowed; all adds, subtracts and negates go through `Adder32`.
- The 6-bit iteration counter and operand muxes live in `muldiv_ctrl`.

## Test plan
- MULT, A = 7, B = −3 → `data_result` = 0xFFFFFFEB, exception = 0, rdy in the cycle after edge N+33.
- MULT, A = 0x00010000, B = 0x00010000 → result = 0, exception = 1; MULT 0x80000000 × 1 → 0x80000000, exception = 0.
- DIV, A = −100, B = 7 → 0xFFFFFFF2 (−14) after edge N+36; DIV 100 / −7 → −14; DIV 0 / 5 → 0.
- DIV 5 / 0 → result = 0, exception = 1; DIV 0x80000000 / 0xFFFFFFFF → result = 0, exception = 1; both at the full fixed latency.
- MULT 3×4 started, then DIV 20/6 at edge N+10 → a single rdy in the cycle after edge N+46, result = 3.
- `reset_n` low at edge N+15 of a MULT → outputs 0 immediately and no rdy. After release, MULT −1 × −1 gives 1, with ctrl_MULT and ctrl_DIV both high → MULT executed.
